// File: rtl/acc_mem_if.sv
// Accelerator <-> memory request/response bundle.
// master = accelerator side, slave = memory responder side.
interface acc_mem_if;
  logic [31:0]  acc2mem_request_address;
  logic [63:0]  acc2mem_request_dirty_mask;
  logic [511:0] acc2mem_request_data;
  logic         acc2mem_request_read;
  logic         acc2mem_request_write;
  logic         mem_request_available;
  logic         mem2acc_response_valid;
  logic [31:0]  mem2acc_response_address;
  logic [511:0] mem2acc_response_data;
  logic         acc_available;

  modport master (
    output acc2mem_request_address, acc2mem_request_dirty_mask, acc2mem_request_data,
           acc2mem_request_read, acc2mem_request_write, acc_available,
    input  mem_request_available, mem2acc_response_valid, mem2acc_response_address,
           mem2acc_response_data
  );

  modport slave (
    input  acc2mem_request_address, acc2mem_request_dirty_mask, acc2mem_request_data,
           acc2mem_request_read, acc2mem_request_write, acc_available,
    output mem_request_available, mem2acc_response_valid, mem2acc_response_address,
           mem2acc_response_data
  );
endinterface

// File: rtl/acc_mem_responder.sv
// Line-organised memory responder: request FIFO + IDLE/ACCESS/RESPOND service FSM.
// Optional ACC_MEM_WRITE_RESP_EN: pure writes also return the merged line as an ack.
module acc_mem_responder #(
  parameter int MEM_LINES  = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  acc_mem_if.slave  bus
);
  localparam int LW = $clog2(MEM_LINES);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [25:0]  line;   // address[31:6]
    logic [63:0]  mask;
    logic [511:0] data;
    logic         rd;
    logic         wr;
  } req_t;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_e;

  req_t          fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  state_e        state_q, state_d;
  req_t          cur_q;
  logic [511:0]  line_q, merged;
  logic [511:0]  mem [MEM_LINES];
  logic [31:0]   resp_addr_q;
  logic [511:0]  resp_data_q;
  logic          avail, push, pop, load_resp, ram_we, need_resp;

  assign avail = reset && (count_q != CW'(FIFO_DEPTH));
  assign push  = (bus.acc2mem_request_read | bus.acc2mem_request_write) & avail;

`ifdef ACC_MEM_WRITE_RESP_EN
  assign need_resp = cur_q.rd | cur_q.wr;
`else
  assign need_resp = cur_q.rd;
`endif

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_ptr_q] <= '{line: bus.acc2mem_request_address[31:6],
                            mask: bus.acc2mem_request_dirty_mask,
                            data: bus.acc2mem_request_data,
                            rd:   bus.acc2mem_request_read,
                            wr:   bus.acc2mem_request_write};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is latched with its RAM line so ACCESS sees both in one cycle.
  always_ff @(posedge clk) begin
    if (pop) begin
      cur_q  <= fifo_q[rd_ptr_q];
      line_q <= mem[fifo_q[rd_ptr_q].line[LW-1:0]];
    end
    if (ram_we)
      mem[cur_q.line[LW-1:0]] <= merged;
  end

  always_comb begin
    merged = line_q;
    for (int b = 0; b < 64; b++)
      if (cur_q.wr && cur_q.mask[b]) merged[8*b +: 8] = cur_q.data[8*b +: 8];
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_resp = 1'b0;
    ram_we    = 1'b0;
    case (state_q)
      IDLE: if (count_q != '0) begin
        pop     = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        ram_we = cur_q.wr;
        if (need_resp) begin
          load_resp = 1'b1;
          state_d   = RESPOND;
        end else begin
          state_d = IDLE;
        end
      end
      RESPOND: if (bus.acc_available) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      resp_addr_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_resp) begin
        resp_addr_q <= {cur_q.line, 6'b0};
        resp_data_q <= merged;
      end
    end
  end

  assign bus.mem_request_available    = avail;
  assign bus.mem2acc_response_valid   = (state_q == RESPOND) && bus.acc_available;
  assign bus.mem2acc_response_address = resp_addr_q;
  assign bus.mem2acc_response_data    = resp_data_q;
endmodule

// File: tb/tb_acc_mem_responder.sv
// Directed bench for acc_mem_responder; expected responses queued at issue,
// checked in order by a negedge monitor.
module tb_acc_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  acc_mem_if bus();

  acc_mem_responder #(.MEM_LINES(256), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

`ifdef ACC_MEM_WRITE_RESP_EN
  localparam bit WR_RESP = 1'b1;
`else
  localparam bit WR_RESP = 1'b0;
`endif

  typedef struct {
    logic [31:0]  a;
    logic [511:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  localparam logic [511:0] ONES  = {16{32'h1}};
  localparam logic [511:0] AAS   = {64{8'hAA}};
  localparam logic [511:0] FIVES = {64{8'h55}};
  localparam logic [511:0] MRG   = {{60{8'hAA}}, {4{8'h55}}};

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.mem2acc_response_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_resp: got address %h expected no response",
                 bus.mem2acc_response_address);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_addr", {480'b0, bus.mem2acc_response_address}, {480'b0, e.a});
        chk("resp_data", bus.mem2acc_response_data, e.d);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] a, input logic [63:0] m, input logic [511:0] d,
                      input bit r, input bit w, input bit track, input logic [511:0] exp);
    int k;
    k = 0;
    bus.acc2mem_request_address    = a;
    bus.acc2mem_request_dirty_mask = m;
    bus.acc2mem_request_data       = d;
    bus.acc2mem_request_read       = r;
    bus.acc2mem_request_write      = w;
    while (!bus.mem_request_available && k < 200) begin cyc(1); k++; end
    if (k == 200) begin
      n_chk++;
      $display("FAIL send_timeout: got no acceptance in 200 cycles expected acceptance");
    end else begin
      if (track && (r || (w && WR_RESP))) begin
        exp_t e;
        e.a = {a[31:6], 6'b0};
        e.d = exp;
        exp_q.push_back(e);
      end
      cyc(1);
    end
    bus.acc2mem_request_read  = 1'b0;
    bus.acc2mem_request_write = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin cyc(1); k++; end
    chk("drain_empty", exp_q.size(), 0);
    cyc(3);
  endtask

  initial begin
    int acc, vcnt, late_avail;
    bit stable;
    logic [511:0] snap, d;
    logic [7:0] b;

    bus.acc2mem_request_address    = '0;
    bus.acc2mem_request_dirty_mask = '0;
    bus.acc2mem_request_data       = '0;
    bus.acc2mem_request_read       = 1'b0;
    bus.acc2mem_request_write      = 1'b0;
    bus.acc_available              = 1'b1;

    // reset state
    cyc(3);
    chk("rst_avail", bus.mem_request_available, 0);
    chk("rst_valid", bus.mem2acc_response_valid, 0);
    chk("rst_addr",  bus.mem2acc_response_address, 0);
    chk("rst_data",  bus.mem2acc_response_data, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_avail", bus.mem_request_available, 1);
    cyc(1);

    // basic write/read with latency, then index wrap
    send(32'h40, '1, ONES, 0, 1, 1, ONES);
    cyc(6);
    send(32'h40, '0, '0, 1, 0, 1, ONES);
    @(negedge clk); chk("lat_n1", bus.mem2acc_response_valid, 0);
    cyc(1);
    @(negedge clk); chk("lat_n2", bus.mem2acc_response_valid, 0);
    cyc(1);
    @(negedge clk); chk("lat_n3", bus.mem2acc_response_valid, 1);
    cyc(1);
    send(32'h4040, '0, '0, 1, 0, 1, ONES);
    drain();

    // partial-mask merge
    send(32'h80, '1, AAS, 0, 1, 1, AAS);
    send(32'h80, 64'hF, FIVES, 0, 1, 1, MRG);
    send(32'h80, '0, '0, 1, 0, 1, MRG);
    drain();

    // backpressure: hold, then exactly one beat
    bus.acc_available = 1'b0;
    send(32'h80, '0, '0, 1, 0, 1, MRG);
    cyc(4);
    snap = bus.mem2acc_response_data;
    stable = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem2acc_response_valid) vcnt++;
      if (bus.mem2acc_response_data !== snap) stable = 1'b0;
      cyc(1);
    end
    chk("bp_valid_low", vcnt, 0);
    chk("bp_stable", stable, 1);
    chk("bp_held_data", snap, MRG);
    bus.acc_available = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.mem2acc_response_valid) vcnt++;
      cyc(1);
    end
    chk("bp_one_beat", vcnt, 1);
    drain();

    // capacity: FIFO_DEPTH queued + 1 in service
    for (int i = 0; i < 8; i++) begin
      b = 8'h10 + 8'(i);
      d = {64{b}};
      send(32'(i) << 6, '1, d, 0, 1, 1, d);
    end
    drain();
    bus.acc_available = 1'b0;
    cyc(2);
    acc = 0;
    late_avail = 0;
    for (int i = 0; i < 8; i++) begin
      bus.acc2mem_request_address = 32'(i) << 6;
      bus.acc2mem_request_read    = 1'b1;
      if (i >= 5 && bus.mem_request_available) late_avail++;
      if (bus.mem_request_available) begin
        exp_t e;
        b = 8'h10 + 8'(i);
        e.a = 32'(i) << 6;
        e.d = {64{b}};
        exp_q.push_back(e);
        acc++;
      end
      cyc(1);
    end
    bus.acc2mem_request_read = 1'b0;
    chk("cap_accepted", acc, 5);
    chk("cap_avail_low", late_avail, 0);
    bus.acc_available = 1'b1;
    drain();

    // pure write (no read strobe)
    send(32'hC0, '1, {64{8'h33}}, 0, 1, 1, {64{8'h33}});
`ifdef ACC_MEM_WRITE_RESP_EN
    drain();
`else
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem2acc_response_valid) vcnt++;
      cyc(1);
    end
    chk("wr_no_resp", vcnt, 0);
`endif
    send(32'hC0, '0, '0, 1, 0, 1, {64{8'h33}});
    drain();

    // reset while in RESPOND
    bus.acc_available = 1'b0;
    send(32'h80, '0, '0, 1, 0, 0, '0);
    cyc(5);
    bus.acc_available = 1'b1;
    reset = 1'b0;
    #1;
    chk("rst_mid_valid", bus.mem2acc_response_valid, 0);
    chk("rst_mid_addr",  bus.mem2acc_response_address, 0);
    cyc(2);
    reset = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.mem2acc_response_valid) vcnt++;
      cyc(1);
    end
    chk("rst_no_stale", vcnt, 0);
    send(32'h80, '0, '0, 1, 0, 1, {64{8'h12}});
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/acc_mem_responder.md
# acc_mem_responder

Memory-side responder for the accelerator request/response interface. It accepts line-wide read and write requests issued by an accelerator, queues them in a small FIFO, and services them against an internal line-organised RAM. Read data is returned on the mem2acc response channel under accelerator backpressure. It is used as the memory model and bring-up target behind accelerator blocks in deploy builds.

## Interface
- MEM_LINES, 256, number of 64-byte lines in the internal RAM (power of two)
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)
- clk  in  1  sole clock; all logic on posedge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- acc2mem_request_address  in  32  byte address; bits [5:0] ignored
- acc2mem_request_dirty_mask  in  64  per-byte write enable; bit i covers data[8i+7:8i]
- acc2mem_request_data  in  512  write line
- acc2mem_request_read  in  1  read request strobe
- acc2mem_request_write  in  1  write request strobe
- mem_request_available  out  1  request accepted this cycle if strobe is high
- mem2acc_response_valid  out  1  response beat, one cycle per response
- mem2acc_response_address  out  32  request address echoed, bits [5:0] forced 0
- mem2acc_response_data  out  512  line contents after the request
- acc_available  in  1  accelerator can take a response this cycle

## Operation
- Accept: read|write high while mem_request_available high → enqueue {address, mask, data, read, write}. Strobes while available is low are ignored, with no side effect.
- mem_request_available = reset deasserted && count != FIFO_DEPTH (combinational from registered count).
- Line index = address[6 +: log2(MEM_LINES)]; higher bits are discarded (wrap modulo MEM_LINES).
- read and write both high: one entry. Write merges first; the response returns the merged line.
- FSM:
  - IDLE: FIFO non-empty → pop head, present RAM read address → ACCESS.
  - ACCESS: RAM line available. If write, merge bytes where mask=1 and write the RAM. If a response is required, load the response registers → RESPOND, else → IDLE.
  - RESPOND: mem2acc_response_valid = acc_available. On a cycle with acc_available=1, → IDLE. Otherwise hold the registers stable.
- Responses are returned in request order. A write with mask 0 is legal and is a no-op on the RAM.
- Enqueue and pop on the same edge: count unchanged.

## Timing
- Request in cycle N with FIFO empty, FSM in IDLE, acc_available=1: response valid in cycle N+3. Peak throughput is one request per 3 cycles.
- Acceptance capacity with responses stalled: FIFO_DEPTH queued plus 1 in service.
- Reset assertion (asynchronous) clears FIFO pointers and count, sets FSM to IDLE, and drives valid, response address and response data to 0. mem_request_available is 0 while reset is asserted and 1 from the first cycle after release.
- RAM contents are not reset. Reset mid-operation discards queued and in-flight requests; a write already in ACCESS at the reset edge may or may not have updated the RAM.
- Unwritten lines read as X; benches write before reading.

## Configuration
- ACC_MEM_WRITE_RESP_EN defined: every write also produces a response carrying the merged line (write acknowledgement).
- ACC_MEM_WRITE_RESP_EN not defined: pure writes go ACCESS → IDLE with no response, giving 2-cycle service. Only requests with read=1 respond.

## Test plan
- Write 0x40, mask all ones, data {16{32'h1}}; then read 0x40 → response 3 cycles after the read cycle, address 0x40, data {16{32'h1}}. Read 0x4040 (MEM_LINES=256, wraps to line 1) → response address 0x4040, data {16{32'h1}}.
- Write 0x80 {64{8'hAA}} with full mask; then write 0x80 {64{8'h55}} with mask 64'hF; then read → bytes 0-3 = 0x55, bytes 4-63 = 0xAA.
- Hold acc_available=0 for 10 cycles while a read is pending → valid stays 0 and data is stable. Release → valid for exactly one cycle with the correct data.
- FIFO_DEPTH=4, acc_available=0, reads to lines 0..7 presented every cycle → exactly 5 accepted, available low from the 6th cycle, later strobes ignored. Release → 5 responses in order for lines 0-4.
- Write with read=0 → response with the merged line when ACC_MEM_WRITE_RESP_EN is defined; no valid within 20 cycles when it is not.
- Assert reset while the FSM is in RESPOND → valid drops immediately and no stale response appears after release. Reading a previously written line still returns its data.
